// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave that behaves like a serial SRAM of 32-bit words (read 0x03 / write 0x02).
// Define SPI_SRAM_SEQ_EN for sequential (auto-incrementing) multi-word transfers within one frame.
module spi_sram_responder #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              CLK,
   input  logic              CS_N,
   input  logic              MOSI,
   output logic              MISO,
   output logic              wr_done,
   output logic              rd_done,
   output logic              bad_cmd,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [31:0]       dbg_rdata
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_HDR    = 3'd1;
   localparam logic [2:0] ST_WDATA  = 3'd2;
   localparam logic [2:0] ST_RDATA  = 3'd3;
   localparam logic [2:0] ST_IGNORE = 3'd4;

   logic              sclk_s1_r, sclk_s2_r, sclk_s3_r;
   logic              cs_s1_r, cs_s2_r;
   logic              mosi_s1_r, mosi_s2_r;
   logic              rise_s, fall_s;
   logic [2:0]        state_r;
   logic [5:0]        bitcnt_r;
   logic [30:0]       in_sr_r;
   logic [31:0]       shift_in_s;
   logic [31:0]       out_sr_r;
   logic [ADDR_W-1:0] index_r;
   logic              armed_r;
   logic              load_r;
   logic              we_s;
   logic [31:0]       mem [0:(2**ADDR_W)-1];
`ifdef SPI_SRAM_SEQ_EN
   logic [ADDR_W-1:0] index_inc_s;
   assign index_inc_s = index_r + 1'b1;
`endif

   assign rise_s     = sclk_s2_r & ~sclk_s3_r;
   assign fall_s     = ~sclk_s2_r & sclk_s3_r;
   assign shift_in_s = {in_sr_r, mosi_s2_r};

   // Synchronizers are free-running so a mid-frame reset still sees live pin levels.
   always_ff @(posedge clk) begin
      sclk_s1_r <= CLK;
      sclk_s2_r <= sclk_s1_r;
      sclk_s3_r <= sclk_s2_r;
      cs_s1_r   <= CS_N;
      cs_s2_r   <= cs_s1_r;
      mosi_s1_r <= MOSI;
      mosi_s2_r <= mosi_s1_r;
   end

   always_comb begin
      we_s = 1'b0;
      if (!reset && !cs_s2_r && (state_r == ST_WDATA) && rise_s && (bitcnt_r == 6'd31)) begin
         we_s = 1'b1;
      end else begin
         we_s = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (we_s) begin
         mem[index_r] <= shift_in_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dbg_rdata <= 32'd0;
      end else begin
         dbg_rdata <= mem[dbg_addr];
      end
   end

   // armed_r blocks header decode after a reset until CS_N has been seen high again.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         bitcnt_r <= 6'd0;
         in_sr_r  <= 31'd0;
         out_sr_r <= 32'd0;
         index_r  <= '0;
         armed_r  <= 1'b0;
         load_r   <= 1'b0;
         MISO     <= 1'b0;
         wr_done  <= 1'b0;
         rd_done  <= 1'b0;
         bad_cmd  <= 1'b0;
      end else begin
         wr_done <= 1'b0;
         rd_done <= 1'b0;
         bad_cmd <= 1'b0;
         load_r  <= 1'b0;
         if (load_r) begin
            out_sr_r <= mem[index_r];
         end
         if (cs_s2_r) begin
            armed_r <= 1'b1;
            state_r <= ST_IDLE;
            MISO    <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  MISO <= 1'b0;
                  if (armed_r) begin
                     state_r  <= ST_HDR;
                     bitcnt_r <= 6'd0;
                     in_sr_r  <= 31'd0;
                  end
               end
               ST_HDR: begin
                  if (rise_s) begin
                     in_sr_r  <= shift_in_s[30:0];
                     bitcnt_r <= bitcnt_r + 6'd1;
                     if (bitcnt_r == 6'd31) begin
                        bitcnt_r <= 6'd0;
                        index_r  <= shift_in_s[ADDR_W-1:0];
                        if (shift_in_s[31:24] == 8'h02) begin
                           state_r <= ST_WDATA;
                        end else if (shift_in_s[31:24] == 8'h03) begin
                           state_r <= ST_RDATA;
                           load_r  <= 1'b1;
                        end else begin
                           bad_cmd <= 1'b1;
                           state_r <= ST_IGNORE;
                        end
                     end
                  end
               end
               ST_WDATA: begin
                  if (rise_s) begin
                     in_sr_r  <= shift_in_s[30:0];
                     bitcnt_r <= bitcnt_r + 6'd1;
                     if (bitcnt_r == 6'd31) begin
                        wr_done <= 1'b1;
`ifdef SPI_SRAM_SEQ_EN
                        bitcnt_r <= 6'd0;
                        index_r  <= index_inc_s;
`else
                        state_r  <= ST_IGNORE;
`endif
                     end
                  end
               end
               ST_RDATA: begin
                  // bit 0 stays on MISO until the master's sampling rise, then the word is over
                  if (fall_s && (bitcnt_r != 6'd32)) begin
                     MISO     <= out_sr_r[31];
                     out_sr_r <= {out_sr_r[30:0], 1'b0};
                     bitcnt_r <= bitcnt_r + 6'd1;
                     if (bitcnt_r == 6'd31) begin
                        rd_done <= 1'b1;
`ifdef SPI_SRAM_SEQ_EN
                        bitcnt_r <= 6'd0;
                        index_r  <= index_inc_s;
                        load_r   <= 1'b1;
`endif
                     end
                  end else if (rise_s && (bitcnt_r == 6'd32)) begin
                     MISO    <= 1'b0;
                     state_r <= ST_IGNORE;
                  end
               end
               ST_IGNORE: begin
                  MISO <= 1'b0;
               end
               default: begin
                  MISO    <= 1'b0;
                  state_r <= ST_IGNORE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: directed frames plus random frames against a word-level memory model.
module tb_spi_sram_responder;

   localparam int AW   = 10;
   localparam int NW   = 1 << AW;
   localparam int HALF = 5;
`ifdef SPI_SRAM_SEQ_EN
   localparam bit SEQ = 1'b1;
`else
   localparam bit SEQ = 1'b0;
`endif

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic          sclk     = 1'b0;
   logic          cs_n     = 1'b1;
   logic          mosi     = 1'b0;
   logic          miso;
   logic          wr_done;
   logic          rd_done;
   logic          bad_cmd;
   logic [AW-1:0] dbg_addr   = '0;
   logic [AW-1:0] dbg_addr_q = '0;
   logic [31:0]   dbg_rdata;

   int total = 0;
   int bad   = 0;
   int wr_cnt = 0, rd_cnt = 0, bad_cnt = 0;
   int exp_wr = 0, exp_rd = 0, exp_bad = 0;
   bit miso_may_drive = 1'b0;
   bit dbg_chk_en     = 1'b0;
   logic wr_prev = 1'b0, rd_prev = 1'b0, bc_prev = 1'b0;

   logic [31:0] mdl   [NW];
   bit          known [NW];
   logic [31:0] tx_q [$];
   logic [31:0] rx_q [$];

   always #5 clk = ~clk;

   spi_sram_responder #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .CLK       (sclk),
      .CS_N      (cs_n),
      .MOSI      (mosi),
      .MISO      (miso),
      .wr_done   (wr_done),
      .rd_done   (rd_done),
      .bad_cmd   (bad_cmd),
      .dbg_addr  (dbg_addr),
      .dbg_rdata (dbg_rdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) dbg_addr_q <= dbg_addr;

   // Per-cycle compare against the model: quiet MISO, debug port contents, single-cycle pulses.
   always @(negedge clk) begin
      if (!miso_may_drive) check("miso_quiet", {31'd0, miso}, 32'd0);
      if (dbg_chk_en && known[dbg_addr_q]) check("dbg_rdata", dbg_rdata, mdl[dbg_addr_q]);
      if (wr_done) begin
         wr_cnt++;
         check("wr_done_width", {31'd0, wr_prev}, 32'd0);
      end
      if (rd_done) begin
         rd_cnt++;
         check("rd_done_width", {31'd0, rd_prev}, 32'd0);
      end
      if (bad_cmd) begin
         bad_cnt++;
         check("bad_cmd_width", {31'd0, bc_prev}, 32'd0);
      end
      wr_prev <= wr_done;
      rd_prev <= rd_done;
      bc_prev <= bad_cmd;
   end

   task automatic push_tx(input logic [31:0] w);
      tx_q.push_back(w);
   endtask

   // One CS_N-low frame; reset_at>0 pulses reset after that many data bits.
   task automatic spi_frame(input logic [7:0] op, input logic [15:0] addr, input int ndata, input int reset_at);
      logic [31:0] hdr;
      logic [31:0] w;
      logic [31:0] rxw;
      int words;
      int idx;
      hdr = {op, 8'h00, addr};
      rxw = 32'd0;
      rx_q.delete();
      dbg_chk_en = 1'b0;
      @(negedge clk);
      cs_n = 1'b0;
      sclk = 1'b0;
      for (int i = 0; i < 32 + ndata; i++) begin
         if (i < 32) begin
            mosi = hdr[31-i];
         end else begin
            w = tx_q[(i-32)/32];
            mosi = w[31-((i-32)%32)];
         end
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         if (i >= 32) begin
            rxw = {rxw[30:0], miso};
            if ((i - 32) % 32 == 31) rx_q.push_back(rxw);
         end
         if (i == 31 && op == 8'h03 && reset_at <= 0) miso_may_drive = 1'b1;
         if (i == 31 && op == 8'h03 && reset_at > 0) miso_may_drive = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
         if (reset_at > 0 && i == 31 + reset_at) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            miso_may_drive = 1'b0;
            check("miso_after_reset", {31'd0, miso}, 32'd0);
         end
      end
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (8) @(negedge clk);
      miso_may_drive = 1'b0;

      words = ndata / 32;
      if (!SEQ && words > 1) words = 1;
      if (reset_at > 0) words = 0;
      idx = int'(addr[AW-1:0]);
      if (op == 8'h02) begin
         for (int k = 0; k < words; k++) begin
            mdl[(idx + k) % NW]   = tx_q[k];
            known[(idx + k) % NW] = 1'b1;
            exp_wr++;
         end
      end else if (op == 8'h03) begin
         for (int k = 0; k < words; k++) begin
            exp_rd++;
            if (known[(idx + k) % NW]) check("read_data", rx_q[k], mdl[(idx + k) % NW]);
         end
      end else begin
         exp_bad++;
      end
      check("wr_done_count", wr_cnt, exp_wr);
      check("rd_done_count", rd_cnt, exp_rd);
      check("bad_cmd_count", bad_cnt, exp_bad);
      dbg_chk_en = 1'b1;
   endtask

   task automatic dbg_peek(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
      dbg_addr = a;
      repeat (2) @(negedge clk);
      check(name, dbg_rdata, exp);
   endtask

   initial begin
      int w0;
      repeat (4) @(negedge clk);
      check("reset_miso", {31'd0, miso}, 32'd0);
      check("reset_wr_done", {31'd0, wr_done}, 32'd0);
      check("reset_rd_done", {31'd0, rd_done}, 32'd0);
      check("reset_bad_cmd", {31'd0, bad_cmd}, 32'd0);
      check("reset_dbg_rdata", dbg_rdata, 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // write then read back 0xDEADBEEF at 0x0012
      tx_q.delete(); push_tx(32'hDEADBEEF);
      spi_frame(8'h02, 16'h0012, 32, 0);
      check("t1_wr_once", wr_cnt, 32'd1);
      tx_q.delete(); push_tx(32'h0000_0000);
      spi_frame(8'h03, 16'h0012, 32, 0);
      check("t1_read_word", rx_q[0], 32'hDEADBEEF);
      dbg_peek(10'h012, 32'hDEADBEEF, "t1_dbg");

      // aborted second write leaves the first word intact
      tx_q.delete(); push_tx(32'h12345678);
      spi_frame(8'h02, 16'h0040, 32, 0);
      tx_q.delete(); push_tx(32'hFFFFFFFF);
      spi_frame(8'h02, 16'h0040, 20, 0);
      check("t2_wr_total", wr_cnt, 32'd2);
      dbg_peek(10'h040, 32'h12345678, "t2_dbg");

      // unknown opcode
      tx_q.delete(); push_tx(32'hCAFEF00D);
      spi_frame(8'h05, 16'h0012, 32, 0);
      check("t3_bad_once", bad_cnt, 32'd1);
      dbg_peek(10'h012, 32'hDEADBEEF, "t3_dbg_012");
      dbg_peek(10'h040, 32'h12345678, "t3_dbg_040");

      // address aliasing above ADDR_W
      tx_q.delete(); push_tx(32'hA5A5A5A5);
      spi_frame(8'h02, 16'h0412, 32, 0);
      tx_q.delete(); push_tx(32'h0000_0000);
      spi_frame(8'h03, 16'h0012, 32, 0);
      check("t4_alias_read", rx_q[0], 32'hA5A5A5A5);

      // reset after 10 read bits, then a clean re-read
      tx_q.delete(); push_tx(32'h0000_0000);
      spi_frame(8'h03, 16'h0012, 32, 10);
      tx_q.delete(); push_tx(32'h0000_0000);
      spi_frame(8'h03, 16'h0012, 32, 0);
      check("t5_reread", rx_q[0], 32'hA5A5A5A5);

`ifdef SPI_SRAM_SEQ_EN
      w0 = wr_cnt;
      tx_q.delete(); push_tx(32'h0000_0001); push_tx(32'h0000_0002);
      spi_frame(8'h02, 16'h03FF, 64, 0);
      check("t6_seq_wr_pulses", wr_cnt - w0, 32'd2);
      dbg_peek(10'h3FF, 32'h0000_0001, "t6_dbg_3ff");
      dbg_peek(10'h000, 32'h0000_0002, "t6_dbg_000");
`else
      w0 = wr_cnt;
`endif

      for (int n = 0; n < 30; n++) begin
         logic [7:0]  op;
         logic [15:0] addr;
         int          nw;
         int          r;
         r    = $urandom_range(0, 9);
         op   = (r < 4) ? 8'h02 : ((r < 9) ? 8'h03 : 8'($urandom_range(4, 255)));
         addr = {6'($urandom), 7'd0, 3'($urandom)};
         nw   = $urandom_range(1, SEQ ? 3 : 2);
         tx_q.delete();
         for (int k = 0; k < nw; k++) push_tx($urandom);
         spi_frame(op, addr, 32 * nw, 0);
         repeat (4) begin
            dbg_addr = {7'd0, 3'($urandom)};
            @(negedge clk);
         end
      end
      check("final_wr_count", wr_cnt, exp_wr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
